// File: rtl/spc700_io_regs_pkg.sv
// Shared constants and types for the SPC700 $00F0-$00FF I/O register file.
package spc700_io_regs_pkg;

    localparam logic [3:0] RegTest     = 4'h0;
    localparam logic [3:0] RegControl  = 4'h1;
    localparam logic [3:0] RegDspAddr  = 4'h2;
    localparam logic [3:0] RegDspData  = 4'h3;
    localparam logic [3:0] RegPort0    = 4'h4;
    localparam logic [3:0] RegPort1    = 4'h5;
    localparam logic [3:0] RegPort2    = 4'h6;
    localparam logic [3:0] RegPort3    = 4'h7;
    localparam logic [3:0] RegScratch0 = 4'h8;
    localparam logic [3:0] RegScratch1 = 4'h9;
    localparam logic [3:0] RegTarget0  = 4'hA;
    localparam logic [3:0] RegTarget1  = 4'hB;
    localparam logic [3:0] RegTarget2  = 4'hC;
    localparam logic [3:0] RegCount0   = 4'hD;
    localparam logic [3:0] RegCount1   = 4'hE;
    localparam logic [3:0] RegCount2   = 4'hF;

    localparam int unsigned CtrlTimerEn0   = 0;
    localparam int unsigned CtrlClrPorts01 = 4;
    localparam int unsigned CtrlClrPorts23 = 5;
    localparam int unsigned CtrlIplEn      = 7;

    localparam logic [7:0] ControlReset = 8'h80;

    typedef struct packed {
        logic [7:0] stage2;
        logic [3:0] cnt;
        logic [7:0] target;
    } timer_state_t;

endpackage

// File: rtl/spc700_timer.sv
// One SPC700 stage-2 timer: divides prescaler ticks by its target and keeps a 4-bit
// clear-on-read counter. SPC700_IO_DBG_EN adds raw target/counter access.
module spc700_timer
    import spc700_io_regs_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       enable_i,
    input  logic       start_i,
    input  logic       tgt_we_i,
    input  logic [7:0] tgt_wd_i,
    input  logic       rd_clr_i,
`ifdef SPC700_IO_DBG_EN
    input  logic       cnt_we_i,
    input  logic [3:0] cnt_wd_i,
    output logic [7:0] tgt_o,
`endif
    output logic [3:0] cnt_o
);

    timer_state_t st_q, st_d;
    logic [7:0]   stage2_inc;
    logic         wrap;

    always_comb begin
        st_d       = st_q;
        stage2_inc = st_q.stage2 + 8'd1;
        // Target 0 matches after the 8-bit wrap, giving a 256-tick period.
        wrap       = enable_i && tick_i && (stage2_inc == st_q.target);
        if (enable_i && tick_i) begin
            st_d.stage2 = wrap ? 8'h00 : stage2_inc;
        end
        if (rd_clr_i) begin
            st_d.cnt = {3'b000, wrap};
        end else if (wrap) begin
            st_d.cnt = st_q.cnt + 4'd1;
        end
        if (start_i) begin
            st_d.stage2 = 8'h00;
            st_d.cnt    = 4'h0;
        end
        if (tgt_we_i) begin
            st_d.target = tgt_wd_i;
        end
`ifdef SPC700_IO_DBG_EN
        if (cnt_we_i) begin
            st_d.cnt = cnt_wd_i;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign cnt_o = st_q.cnt;
`ifdef SPC700_IO_DBG_EN
    assign tgt_o = st_q.target;
`endif

endmodule

// File: rtl/spc700_io_regs.sv
// SPC700 $00F0-$00FF register file: CONTROL, DSP window, mailbox ports, scratch and timers.
// Define SPC700_IO_DBG_EN to add a side-effect-free raw debug access port.
module spc700_io_regs
    import spc700_io_regs_pkg::*;
#(
    parameter int unsigned PRESCALE_T01 = 128,
    parameter int unsigned PRESCALE_T2  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    input  logic        RD,
    input  logic        WR,
    output logic        SEL,
    output logic [7:0]  D_OUT,
    output logic        IPL_EN,
    output logic [7:0]  DSP_ADDR,
    output logic [7:0]  DSP_DO,
    output logic        DSP_WR,
    input  logic [7:0]  DSP_DI,
    input  logic        TIMER_CE,
    input  logic [1:0]  SNES_A,
    input  logic        SNES_WR,
    input  logic [7:0]  SNES_DI,
    output logic [7:0]  SNES_DO
`ifdef SPC700_IO_DBG_EN
    ,
    input  logic [7:0]  DBG_REG,
    input  logic [7:0]  DBG_DAT_IN,
    input  logic        DBG_DAT_WR,
    output logic [7:0]  DBG_DAT_OUT
`endif
);

    localparam int unsigned Pre01W = (PRESCALE_T01 > 1) ? $clog2(PRESCALE_T01) : 1;
    localparam int unsigned Pre2W  = (PRESCALE_T2 > 1) ? $clog2(PRESCALE_T2) : 1;

    logic [Pre01W-1:0] pre01_q, pre01_d;
    logic [Pre2W-1:0]  pre2_q, pre2_d;
    logic [7:0]        control_q, control_d, dsp_addr_q, dsp_addr_d, dsp_do_q, dsp_do_d;
    logic              dsp_wr_q, dsp_wr_d;
    logic [3:0][7:0]   in_q, in_d, out_q, out_d;
    logic [1:0][7:0]   scratch_q, scratch_d;
    logic              tick01, tick2, wr_acc, rd_acc;
    logic [2:0]        tick, start, tgt_we, rd_clr;
    logic [7:0]        tgt_wd;
    logic [2:0][3:0]   cnt;
`ifdef SPC700_IO_DBG_EN
    logic [7:0]        test_q, test_d;
    logic              dbg_we;
    logic [2:0]        cnt_we;
    logic [2:0][7:0]   tgt;
    assign dbg_we = !EN && DBG_DAT_WR && (DBG_REG[7:4] == 4'hF);
`endif

    assign SEL    = (A[15:4] == 12'h00F);
    assign wr_acc = EN && SEL && WR;
    assign rd_acc = EN && SEL && RD;
    assign tick01 = TIMER_CE && (pre01_q == Pre01W'(PRESCALE_T01 - 1));
    assign tick2  = TIMER_CE && (pre2_q == Pre2W'(PRESCALE_T2 - 1));
    assign tick   = {tick2, tick01, tick01};

    always_comb begin
        pre01_d = TIMER_CE ? (tick01 ? '0 : pre01_q + Pre01W'(1)) : pre01_q;
        pre2_d  = TIMER_CE ? (tick2 ? '0 : pre2_q + Pre2W'(1)) : pre2_q;
        tgt_wd  = D_IN;
        for (int n = 0; n < 3; n++) begin
            start[n]  = wr_acc && (A[3:0] == RegControl) && D_IN[CtrlTimerEn0 + n]
                        && !control_q[CtrlTimerEn0 + n];
            tgt_we[n] = wr_acc && (A[3:0] == RegTarget0 + 4'(n));
            rd_clr[n] = rd_acc && (A[3:0] == RegCount0 + 4'(n));
        end
`ifdef SPC700_IO_DBG_EN
        for (int n = 0; n < 3; n++) begin
            cnt_we[n] = dbg_we && (DBG_REG[3:0] == RegCount0 + 4'(n));
            if (dbg_we && (DBG_REG[3:0] == RegTarget0 + 4'(n))) begin
                tgt_we[n] = 1'b1;
            end
        end
        if (dbg_we) begin
            tgt_wd = DBG_DAT_IN;
        end
`endif
    end

    for (genvar n = 0; n < 3; n++) begin : g_timer
        spc700_timer u_timer (
            .clk_i    (CLK),
            .rst_i    (RST),
            .tick_i   (tick[n]),
            .enable_i (control_q[CtrlTimerEn0 + n]),
            .start_i  (start[n]),
            .tgt_we_i (tgt_we[n]),
            .tgt_wd_i (tgt_wd),
            .rd_clr_i (rd_clr[n]),
`ifdef SPC700_IO_DBG_EN
            .cnt_we_i (cnt_we[n]),
            .cnt_wd_i (DBG_DAT_IN[3:0]),
            .tgt_o    (tgt[n]),
`endif
            .cnt_o    (cnt[n])
        );
    end

    always_comb begin
        control_d  = control_q;
        dsp_addr_d = dsp_addr_q;
        dsp_do_d   = dsp_do_q;
        dsp_wr_d   = 1'b0;
        in_d       = in_q;
        out_d      = out_q;
        scratch_d  = scratch_q;
`ifdef SPC700_IO_DBG_EN
        test_d     = test_q;
        if (wr_acc && (A[3:0] == RegTest)) test_d = D_IN;
        if (dbg_we) begin
            case (DBG_REG[3:0])
                RegTest:                              test_d = DBG_DAT_IN;
                RegControl:                           control_d = DBG_DAT_IN & 8'h87;
                RegDspAddr:                           dsp_addr_d = DBG_DAT_IN;
                RegDspData:                           dsp_do_d = DBG_DAT_IN;
                RegPort0, RegPort1, RegPort2, RegPort3: in_d[DBG_REG[1:0]] = DBG_DAT_IN;
                RegScratch0, RegScratch1:             scratch_d[DBG_REG[0]] = DBG_DAT_IN;
                default: ;
            endcase
        end
`endif
        if (wr_acc) begin
            case (A[3:0])
                RegControl: begin
                    control_d = {D_IN[CtrlIplEn], 4'b0000, D_IN[2:0]};
                    if (D_IN[CtrlClrPorts01]) begin
                        in_d[0] = 8'h00;
                        in_d[1] = 8'h00;
                    end
                    if (D_IN[CtrlClrPorts23]) begin
                        in_d[2] = 8'h00;
                        in_d[3] = 8'h00;
                    end
                end
                RegDspAddr: dsp_addr_d = D_IN;
                RegDspData: begin
                    dsp_do_d = D_IN;
                    dsp_wr_d = 1'b1;
                end
                RegPort0, RegPort1, RegPort2, RegPort3: out_d[A[1:0]] = D_IN;
                RegScratch0, RegScratch1:             scratch_d[A[0]] = D_IN;
                default: ;
            endcase
        end
        // SNES-side write lands after any CONTROL clear so it wins on a shared edge.
        if (SNES_WR) in_d[SNES_A] = SNES_DI;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre01_q    <= '0;
            pre2_q     <= '0;
            control_q  <= ControlReset;
            dsp_addr_q <= 8'h00;
            dsp_do_q   <= 8'h00;
            dsp_wr_q   <= 1'b0;
            in_q       <= '0;
            out_q      <= '0;
            scratch_q  <= '0;
`ifdef SPC700_IO_DBG_EN
            test_q     <= 8'h00;
`endif
        end else begin
            pre01_q    <= pre01_d;
            pre2_q     <= pre2_d;
            control_q  <= control_d;
            dsp_addr_q <= dsp_addr_d;
            dsp_do_q   <= dsp_do_d;
            dsp_wr_q   <= dsp_wr_d;
            in_q       <= in_d;
            out_q      <= out_d;
            scratch_q  <= scratch_d;
`ifdef SPC700_IO_DBG_EN
            test_q     <= test_d;
`endif
        end
    end

    always_comb begin
        D_OUT = 8'h00;
        if (SEL) begin
            case (A[3:0])
                RegTest, RegControl:                  D_OUT = 8'h00;
                RegDspAddr:                           D_OUT = dsp_addr_q;
                RegDspData:                           D_OUT = DSP_DI;
                RegPort0, RegPort1, RegPort2, RegPort3: D_OUT = in_q[A[1:0]];
                RegScratch0, RegScratch1:             D_OUT = scratch_q[A[0]];
                RegCount0:                            D_OUT = {4'h0, cnt[0]};
                RegCount1:                            D_OUT = {4'h0, cnt[1]};
                RegCount2:                            D_OUT = {4'h0, cnt[2]};
                default:                              D_OUT = 8'h00;
            endcase
        end
    end

`ifdef SPC700_IO_DBG_EN
    always_comb begin
        DBG_DAT_OUT = 8'h00;
        if (DBG_REG[7:4] == 4'hF) begin
            case (DBG_REG[3:0])
                RegTest:                              DBG_DAT_OUT = test_q;
                RegControl:                           DBG_DAT_OUT = control_q;
                RegDspAddr:                           DBG_DAT_OUT = dsp_addr_q;
                RegDspData:                           DBG_DAT_OUT = dsp_do_q;
                RegPort0, RegPort1, RegPort2, RegPort3: DBG_DAT_OUT = in_q[DBG_REG[1:0]];
                RegScratch0, RegScratch1:             DBG_DAT_OUT = scratch_q[DBG_REG[0]];
                RegTarget0:                           DBG_DAT_OUT = tgt[0];
                RegTarget1:                           DBG_DAT_OUT = tgt[1];
                RegTarget2:                           DBG_DAT_OUT = tgt[2];
                RegCount0:                            DBG_DAT_OUT = {4'h0, cnt[0]};
                RegCount1:                            DBG_DAT_OUT = {4'h0, cnt[1]};
                default:                              DBG_DAT_OUT = {4'h0, cnt[2]};
            endcase
        end
    end
`endif

    assign IPL_EN   = control_q[CtrlIplEn];
    assign DSP_ADDR = dsp_addr_q;
    assign DSP_DO   = dsp_do_q;
    assign DSP_WR   = dsp_wr_q;
    assign SNES_DO  = out_q[SNES_A];

endmodule

// File: tb/tb_spc700_io_regs.sv
// Directed and randomized checks of spc700_io_regs against a behavioural register model.
module tb_spc700_io_regs;

    localparam int unsigned P01 = 32;
    localparam int unsigned P2  = 8;

    logic        CLK = 1'b0;
    logic        RST, EN, RD, WR, TIMER_CE, SNES_WR;
    logic        SEL, IPL_EN, DSP_WR;
    logic [15:0] A;
    logic [7:0]  D_IN, D_OUT, DSP_ADDR, DSP_DO, DSP_DI, SNES_DI, SNES_DO;
    logic [1:0]  SNES_A;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pre01, m_pre2;
    bit m_en[3];
    int m_stage[3], m_cnt[3], m_tgt[3];
    int m_in[4], m_out[4], m_scr[2];
    int m_dsp_addr, m_dsp_do;
    bit m_dsp_wr, m_ipl;

    spc700_io_regs #(
        .PRESCALE_T01 (P01),
        .PRESCALE_T2  (P2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .A        (A),
        .D_IN     (D_IN),
        .RD       (RD),
        .WR       (WR),
        .SEL      (SEL),
        .D_OUT    (D_OUT),
        .IPL_EN   (IPL_EN),
        .DSP_ADDR (DSP_ADDR),
        .DSP_DO   (DSP_DO),
        .DSP_WR   (DSP_WR),
        .DSP_DI   (DSP_DI),
        .TIMER_CE (TIMER_CE),
        .SNES_A   (SNES_A),
        .SNES_WR  (SNES_WR),
        .SNES_DI  (SNES_DI),
        .SNES_DO  (SNES_DO)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pre01 = 0; m_pre2 = 0; m_ipl = 1'b1; m_dsp_addr = 0; m_dsp_do = 0; m_dsp_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 1'b0; m_stage[i] = 0; m_cnt[i] = 0; m_tgt[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_in[i] = 0; m_out[i] = 0;
        end
        m_scr[0] = 0; m_scr[1] = 0;
    endtask

    function automatic int model_read(input int lo);
        if (lo == 2) return m_dsp_addr;
        if (lo == 3) return int'(DSP_DI);
        if (lo >= 4 && lo <= 7) return m_in[lo - 4];
        if (lo == 8 || lo == 9) return m_scr[lo - 8];
        if (lo >= 13) return m_cnt[lo - 13];
        return 0;
    endfunction

    function automatic int exp_dout();
        if (A[15:4] != 12'h00F) return 0;
        return model_read(int'(A[3:0]));
    endfunction

    // Applies one clock edge worth of behaviour to the model using the current inputs.
    task automatic model_step();
        bit t01, t2, tk, inc, wr, rd;
        int lo, period;
        if (RST) begin
            model_reset();
            return;
        end
        lo  = int'(A[3:0]);
        wr  = EN && WR && (A[15:4] == 12'h00F);
        rd  = EN && RD && (A[15:4] == 12'h00F);
        t01 = TIMER_CE && (m_pre01 == P01 - 1);
        t2  = TIMER_CE && (m_pre2 == P2 - 1);
        for (int n = 0; n < 3; n++) begin
            tk  = (n == 2) ? t2 : t01;
            inc = 1'b0;
            period = (m_tgt[n] == 0) ? 256 : m_tgt[n];
            if (m_en[n] && tk) begin
                m_stage[n]++;
                if (m_stage[n] == period) begin
                    m_stage[n] = 0;
                    inc = 1'b1;
                end else if (m_stage[n] > 255) begin
                    m_stage[n] = 0;
                end
            end
            if (inc) m_cnt[n] = (m_cnt[n] + 1) % 16;
            if (rd && lo == 13 + n) m_cnt[n] = inc ? 1 : 0;
            if (wr && lo == 1 && D_IN[n] && !m_en[n]) begin
                m_stage[n] = 0;
                m_cnt[n]   = 0;
            end
        end
        if (TIMER_CE) begin
            m_pre01 = (m_pre01 + 1) % P01;
            m_pre2  = (m_pre2 + 1) % P2;
        end
        m_dsp_wr = 1'b0;
        if (wr) begin
            if (lo == 1) begin
                for (int n = 0; n < 3; n++) m_en[n] = D_IN[n];
                m_ipl = D_IN[7];
                if (D_IN[4]) begin m_in[0] = 0; m_in[1] = 0; end
                if (D_IN[5]) begin m_in[2] = 0; m_in[3] = 0; end
            end
            if (lo == 2) m_dsp_addr = int'(D_IN);
            if (lo == 3) begin m_dsp_do = int'(D_IN); m_dsp_wr = 1'b1; end
            if (lo >= 4 && lo <= 7) m_out[lo - 4] = int'(D_IN);
            if (lo == 8 || lo == 9) m_scr[lo - 8] = int'(D_IN);
            if (lo >= 10 && lo <= 12) m_tgt[lo - 10] = int'(D_IN);
        end
        if (SNES_WR) m_in[SNES_A] = int'(SNES_DI);
    endtask

    task automatic do_cycle(input logic en, input logic rd, input logic wr, input logic [15:0] a,
                            input logic [7:0] d, input logic ce, input string tag);
        EN = en; RD = rd; WR = wr; A = a; D_IN = d; TIMER_CE = ce;
        #1;
        if (rd) check_eq(tag, D_OUT, exp_dout());
        model_step();
        @(posedge CLK);
        #1;
        EN = 1'b0; RD = 1'b0; WR = 1'b0; TIMER_CE = 1'b0; SNES_WR = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] reg_lo, input logic [7:0] d);
        do_cycle(1'b1, 1'b0, 1'b1, {8'h00, reg_lo}, d, 1'b0, "wr");
    endtask

    task automatic cpu_rd(input logic [7:0] reg_lo, input string tag, input logic ce);
        do_cycle(1'b1, 1'b1, 1'b0, {8'h00, reg_lo}, 8'h00, ce, tag);
    endtask

    task automatic ce_pulses(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, "ce");
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_ipl"}, IPL_EN, m_ipl);
        check_eq({tag, "_dsp_addr"}, DSP_ADDR, m_dsp_addr);
        check_eq({tag, "_dsp_do"}, DSP_DO, m_dsp_do);
        check_eq({tag, "_dsp_wr"}, DSP_WR, m_dsp_wr);
        check_eq({tag, "_snes_do"}, SNES_DO, m_out[SNES_A]);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; RD = 1'b0; WR = 1'b0; A = 16'h0000; D_IN = 8'h00;
        TIMER_CE = 1'b0; SNES_WR = 1'b0; SNES_A = 2'd0; SNES_DI = 8'h00; DSP_DI = 8'h00;

        // Reset with a competing write and CE; reset must win.
        do_cycle(1'b1, 1'b0, 1'b1, 16'h00F8, 8'hFF, 1'b1, "rst");
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, "rst");
        RST = 1'b0;
        check_eq("rst_ipl_en", IPL_EN, 1'b1);
        check_eq("rst_dsp_wr", DSP_WR, 1'b0);
        for (int s = 0; s < 4; s++) begin
            SNES_A = 2'(s);
            #1;
            check_eq("rst_snes_do", SNES_DO, 8'h00);
        end
        for (int i = 1; i < 16; i++) cpu_rd(8'hF0 + 8'(i), "rst_read", 1'b0);
        A = 16'h01F5;
        #1;
        check_eq("sel_outside", SEL, 1'b0);
        A = 16'h00F5;
        #1;
        check_eq("sel_inside", SEL, 1'b1);

        // Timer 0 with target 2: two stage-1 ticks give one count, read clears it.
        cpu_wr(8'hFA, 8'h02);
        cpu_wr(8'hF1, 8'h01);
        ce_pulses(2 * P01);
        cpu_rd(8'hFD, "t0_count", 1'b0);
        cpu_rd(8'hFD, "t0_reread", 1'b0);

        // Timer 2 with target 0 (256 period), then sixteen unread counts wrap to zero.
        cpu_wr(8'hFC, 8'h00);
        cpu_wr(8'hF1, 8'h04);
        ce_pulses(256 * P2);
        cpu_rd(8'hFF, "t2_t256", 1'b0);
        ce_pulses(16 * 256 * P2);
        cpu_rd(8'hFF, "t2_wrap", 1'b0);

        // Mailbox in-latch, CONTROL clear, and same-edge SNES write priority.
        SNES_A = 2'd1; SNES_WR = 1'b1; SNES_DI = 8'h5A;
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, "snes_wr");
        cpu_rd(8'hF5, "port1_in", 1'b0);
        cpu_wr(8'hF1, 8'h10);
        cpu_rd(8'hF5, "port1_cleared", 1'b0);
        SNES_A = 2'd1; SNES_WR = 1'b1; SNES_DI = 8'h5A;
        cpu_wr(8'hF1, 8'h10);
        cpu_rd(8'hF5, "port1_clr_vs_wr", 1'b0);
        cpu_wr(8'hF6, 8'h3C);
        SNES_A = 2'd2;
        #1;
        check_outputs("port2_out");

        // DSP window.
        cpu_wr(8'hF2, 8'h4C);
        cpu_wr(8'hF3, 8'h33);
        check_eq("dsp_wr_pulse", DSP_WR, 1'b1);
        check_outputs("dsp_write");
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, "idle");
        check_eq("dsp_wr_single", DSP_WR, 1'b0);
        DSP_DI = 8'hA7;
        cpu_rd(8'hF3, "dsp_di_read", 1'b0);

        // Counter read landing on the same edge as an increment.
        cpu_wr(8'hFC, 8'h01);
        cpu_wr(8'hF1, 8'h04);
        for (int k = 0; k < 200 && !(m_cnt[2] >= 2 && m_pre2 == P2 - 1); k++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, "ce");
        end
        cpu_rd(8'hFF, "rd_coincide_old", 1'b1);
        cpu_rd(8'hFF, "rd_coincide_new", 1'b0);

        // Reset in the middle of counting.
        cpu_wr(8'hFA, 8'h03);
        cpu_wr(8'hFB, 8'h02);
        cpu_wr(8'hF1, 8'h07);
        ce_pulses(300);
        RST = 1'b1;
        do_cycle(1'b1, 1'b0, 1'b1, 16'h00F5, 8'h99, 1'b1, "rst_mid");
        RST = 1'b0;
        check_eq("rst_mid_ipl_en", IPL_EN, 1'b1);
        check_outputs("rst_mid");
        for (int i = 13; i < 16; i++) cpu_rd(8'hF0 + 8'(i), "rst_mid_cnt", 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 3000; it++) begin
            int         op;
            logic [3:0] lo;
            logic [7:0] d;
            logic       ce;
            op     = $urandom_range(0, 9);
            lo     = 4'($urandom_range(0, 15));
            d      = 8'($urandom);
            ce     = ($urandom_range(0, 3) != 0);
            SNES_A = 2'($urandom);
            DSP_DI = 8'($urandom);
            case (op)
                3: begin
                    lo = 4'($urandom_range(1, 12));
                    if (lo >= 4'hA) d = 8'($urandom_range(1, 6));
                    do_cycle(1'b1, 1'b0, 1'b1, {12'h00F, lo}, d, ce, "rand_wr");
                end
                4, 5, 9: do_cycle(1'b1, 1'b1, 1'b0, {12'h00F, lo}, 8'h00, ce, "rand_rd");
                6: begin
                    SNES_WR = 1'b1;
                    SNES_DI = d;
                    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, ce, "rand_snes");
                end
                7: do_cycle(1'b0, 1'b1, 1'b1, {12'h00F, lo}, d, ce, "rand_noen");
                8: do_cycle(1'b1, 1'b1, 1'b1, {12'h01F, lo}, d, ce, "rand_oob");
                default: do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, ce, "rand_idle");
            endcase
            check_outputs("rand");
        end
        for (int i = 0; i < 16; i++) cpu_rd(8'hF0 + 8'(i), "final_read", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
